layer_scheduler: RTL
====================

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 Parameter N_IN, default 9: inputs per neuron; SHALL be >= 1.
REQ-002 Parameter N_NEUR, default 4: neurons in the layer, time-multiplexed on one MAC; SHALL be >= 1.
REQ-003 Parameter DW, default 9: unsigned input and activation width.
REQ-004 Parameter WW, default 9: signed two's-complement weight width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle request to evaluate the layer.
REQ-008 in_vec  input  N_IN*DW  input vector; element k at bits [k*DW +: DW].
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 w_rd_en  output  1  weight-memory read strobe.
REQ-011 w_addr  output  max(1,clog2(N_NEUR*N_IN))  weight address = neuron*N_IN + k.
REQ-012 w_data  input  WW  signed weight, valid exactly one cycle after w_rd_en.
REQ-013 out_valid  output  1  activation available.
REQ-014 out_ready  input  1  consumer accepts activation when high with out_valid.
REQ-015 out_data  output  DW  activation result.
REQ-016 out_idx  output  max(1,clog2(N_NEUR))  neuron index of out_data.
REQ-017 done  output  1  one-cycle pulse after the last neuron is accepted.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN, EMIT, DONE.
REQ-019 IDLE: start=1 SHALL capture in_vec into an internal register, set neuron=0, k=0, clear accumulator, go RUN.
REQ-020 RUN: w_rd_en=1, w_addr=neuron*N_IN+k, one read per cycle; after k=N_IN-1 go DRAIN.
REQ-021 Each cycle after a read, accumulator SHALL add zero-extended in_vec[k] times signed w_data.
REQ-022 Accumulator width SHALL be DW+WW+clog2(N_IN)+1 signed; overflow is impossible by construction.
REQ-023 DRAIN: accumulate final product; register out_data = 0 if sum < 0, 2^DW-1 if sum > 2^DW-1, else sum; go EMIT.
REQ-024 Latency: with start sampled at edge 0, w_rd_en high cycles 1..N_IN, out_valid high from cycle N_IN+2.
REQ-025 EMIT: out_valid=1, out_data and out_idx held stable until out_valid&&out_ready; w_rd_en=0 throughout.
REQ-026 On handshake with neuron<N_NEUR-1: neuron+1, k=0, clear accumulator, go RUN next cycle.
REQ-027 On handshake with neuron=N_NEUR-1: go DONE; done=1 for that one cycle; then IDLE.
REQ-028 start SHALL be ignored in every state except IDLE, including DONE; in_vec changes while busy SHALL not affect results.
REQ-029 w_data SHALL be ignored in cycles not following a w_rd_en.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, busy=0, w_rd_en=0, w_addr=0, out_valid=0, out_data=0, out_idx=0, done=0, accumulator=0.
REQ-031 Reset mid-operation SHALL abandon the layer; no out_valid or done is produced for it.
REQ-032 First start after rst_n deasserts SHALL behave as from power-up.

Structure
REQ-033 Shared package nn_pkg SHALL hold the state enum, accumulator-width function and saturation helper.
REQ-034 The accumulator (clear, enable, signed multiply-add) SHALL be a sub-module nn_mac; the FSM and counters stay in layer_scheduler.

Verification
REQ-035 N_IN=9, N_NEUR=2, all inputs 1, neuron0 weights +1, neuron1 weights -1, out_ready=1 -> (idx0, 9), (idx1, 0), done one cycle after the second handshake.
REQ-036 All inputs 511, all weights +255 -> out_data 511 (saturated); all weights -256 -> 0.
REQ-037 out_ready low 5 cycles during EMIT -> out_valid held, out_data/out_idx stable, w_rd_en=0, no state advance.
REQ-038 start pulsed during RUN and in the DONE cycle -> ignored; exactly N_NEUR results and one done.
REQ-039 rst_n low during RUN at k=4 -> all outputs 0 asynchronously; a later start with REQ-035 stimulus gives identical results.
REQ-040 Latency check, N_IN=9: start at edge 0 -> w_rd_en cycles 1-9, addresses 0-8, first out_valid at cycle 11.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the layer scheduler: FSM states, width helpers and
// the activation clamp used when a neuron's sum is finalised.
package nn_pkg;

  // Controller states of the layer scheduler.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Width of the intermediate value handed to the clamp helper.
  localparam int SAT_W = 64;

  // Signed accumulator width: a full product plus log2 growth over N_IN terms.
  function automatic int acc_width(input int dw, input int ww, input int n_in);
    return dw + ww + $clog2(n_in) + 1;
  endfunction

  // Index/address width, never narrower than one bit.
  function automatic int idx_width(input int n);
    if ($clog2(n) < 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Clamp a signed sum into the unsigned range [0, 2^dw-1].
  function automatic logic [SAT_W-1:0] sat_unsigned(input logic signed [SAT_W-1:0] sum,
                                                    input int dw);
    logic signed [SAT_W-1:0] max_v;
    max_v = (64'sd1 <<< dw) - 64'sd1;
    if (sum < 64'sd0) begin
      return {SAT_W{1'b0}};
    end else if (sum > max_v) begin
      return max_v;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Signed multiply-accumulate used by the layer scheduler. The unsigned
// operand is zero-extended, the weight is sign-extended; o_sum_nxt exposes
// the value the accumulator will take so the final term can be used at once.
module nn_mac
  import nn_pkg::*;
#(
  parameter int DW = 9,
  parameter int WW = 9,
  parameter int AW = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [DW-1:0]        i_a,
  input  logic signed [WW-1:0] i_b,
  output logic signed [AW-1:0] o_sum_nxt
);

  logic signed [AW-1:0] w_a_ext;
  logic signed [AW-1:0] w_b_ext;
  logic signed [AW-1:0] w_prod;
  logic signed [AW-1:0] r_acc;

  assign w_a_ext = AW'(signed'({1'b0, i_a}));
  assign w_b_ext = AW'(i_b);
  assign w_prod  = w_a_ext * w_b_ext;

  // Next accumulator value: add the product only when a term is valid.
  always_comb begin
    o_sum_nxt = r_acc;
    if (i_en) begin
      o_sum_nxt = r_acc + w_prod;
    end else begin
      o_sum_nxt = r_acc;
    end
  end

  // Accumulator register; clear wins over accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum_nxt;
    end else begin
      r_acc <= r_acc;
    end
  end

endmodule

// File: rtl/layer_scheduler.sv
// Evaluates a fully-connected layer of N_NEUR neurons on a single MAC.
// Each neuron reads N_IN weights (one per cycle), accumulates the products
// with the captured input vector, clamps the sum and offers it on a
// valid/ready output. All outputs are registered.
module layer_scheduler
  import nn_pkg::*;
#(
  parameter  int N_IN    = 9,
  parameter  int N_NEUR  = 4,
  parameter  int DW      = 9,
  parameter  int WW      = 9,
  localparam int AW_ADDR = idx_width(N_NEUR * N_IN),
  localparam int NW      = idx_width(N_NEUR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_IN*DW-1:0]   in_vec,
  output logic                 busy,
  output logic                 w_rd_en,
  output logic [AW_ADDR-1:0]   w_addr,
  input  logic signed [WW-1:0] w_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [NW-1:0]        out_idx,
  output logic                 done
);

  localparam int              ACC_W  = acc_width(DW, WW, N_IN);
  localparam int              KW     = idx_width(N_IN);
  localparam logic [KW-1:0]   K_LAST = KW'(N_IN - 1);
  localparam logic [NW-1:0]   N_LAST = NW'(N_NEUR - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [N_IN*DW-1:0]   r_vec;
  logic [KW-1:0]        r_k;
  logic [KW-1:0]        r_k_d;
  logic [NW-1:0]        r_neuron;
  logic [AW_ADDR-1:0]   r_addr;
  logic                 r_rd_d;
  logic                 r_busy;
  logic                 r_rd_en;
  logic                 r_out_valid;
  logic [DW-1:0]        r_out_data;
  logic [NW-1:0]        r_out_idx;
  logic                 r_done;

  logic                 w_hs;
  logic                 w_start_ok;
  logic                 w_mac_clr;
  logic [DW-1:0]        w_elem;
  logic signed [ACC_W-1:0] w_sum_nxt;
  logic [SAT_W-1:0]     w_sat;

  assign busy      = r_busy;
  assign w_rd_en   = r_rd_en;
  assign w_addr    = r_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign done      = r_done;

  // out_valid is only ever high in EMIT, so this is the EMIT handshake.
  assign w_hs       = r_out_valid & out_ready;
  assign w_start_ok = (r_state == IDLE) & start;
  assign w_mac_clr  = w_start_ok | w_hs;
  assign w_sat      = sat_unsigned(SAT_W'(w_sum_nxt), DW);

  // Select the captured input element that pairs with the weight now on w_data.
  always_comb begin
    w_elem = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_elem = w_elem | ((r_k_d == KW'(k)) ? r_vec[k*DW +: DW] : {DW{1'b0}});
    end
  end

  nn_mac #(
    .DW (DW),
    .WW (WW),
    .AW (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_mac_clr),
    .i_en      (r_rd_d),
    .i_a       (w_elem),
    .i_b       (w_data),
    .o_sum_nxt (w_sum_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (r_k == K_LAST) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        w_state_nxt = EMIT;
      end
      EMIT: begin
        if (w_hs) begin
          if (r_neuron == N_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_state_nxt = EMIT;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Input capture, read counters and the one-cycle read-data tracking.
  // The address advances by one on every read and once more when moving
  // to the next neuron, so it always equals neuron*N_IN + k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_k      <= '0;
      r_k_d    <= '0;
      r_neuron <= '0;
      r_addr   <= '0;
      r_rd_d   <= 1'b0;
    end else begin
      r_k_d  <= r_k;
      r_rd_d <= r_rd_en;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vec    <= in_vec;
            r_k      <= '0;
            r_neuron <= '0;
            r_addr   <= '0;
          end
        end
        RUN: begin
          if (r_k != K_LAST) begin
            r_k    <= r_k + KW'(1);
            r_addr <= r_addr + AW_ADDR'(1);
          end
        end
        EMIT: begin
          if (w_hs && (r_neuron != N_LAST)) begin
            r_neuron <= r_neuron + NW'(1);
            r_k      <= '0;
            r_addr   <= r_addr + AW_ADDR'(1);
          end
        end
        default: begin
          r_k <= r_k;
        end
      endcase
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != IDLE);
      r_rd_en     <= (w_state_nxt == RUN);
      r_out_valid <= (w_state_nxt == EMIT);
      r_done      <= (w_state_nxt == DONE);
      if (r_state == DRAIN) begin
        r_out_data <= w_sat[DW-1:0];
        r_out_idx  <= r_neuron;
      end
    end
  end

endmodule
